// File: rtl/grostl_subshift_dp64.sv
// Groestl-256 SubBytes + ShiftBytes stage on a 64-bit column stream.
// Columns are substituted on the way in, buffered, and then drained row-shifted.

module grostl_sbox_lut (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] acc;
      logic [7:0] m;
      acc = 8'h00;
      m   = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) acc = acc ^ m;
         m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   logic [7:0] pw;
   logic [7:0] inv;

   // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine map.
   always_comb begin
      pw  = gf_mul(a, a);
      inv = pw;
      for (int k = 2; k < 8; k++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module grostl_subshift_dp64 #(
   parameter int REG_SBOX = 0,
   parameter int NCOLS    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_col,
   input  logic        in_perm_q,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_col,
   output logic        busy
);
   if (NCOLS != 8) begin : g_ncols_check
      $error("grostl_subshift_dp64: only NCOLS = 8 is supported");
   end

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Q-permutation row offsets, row 0 in the low slice.
   localparam logic [23:0] SIGMA_Q = {3'd6, 3'd4, 3'd2, 3'd0, 3'd7, 3'd5, 3'd3, 3'd1};

   logic [1:0]  state, state_nxt;
   logic [2:0]  wcnt, rcnt, rcnt_nxt;
   logic        perm_q;
   logic [63:0] col_buf [8];
   logic [63:0] buf_view [8];
   logic [63:0] sub_col;
   logic [63:0] shifted;
   logic        in_hs, out_hs;
   logic        wr_en;
   logic [2:0]  wr_idx;
   logic [63:0] wr_data;
   logic        pend_vld;

   assign in_ready  = (state == ST_LOAD);
   assign out_valid = (state == ST_DRAIN);
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign busy      = (state != ST_LOAD) | (wcnt != 3'd0) | pend_vld;

   for (genvar k = 0; k < 8; k++) begin : g_sbox
      grostl_sbox_lut u_sbox (
         .a (in_col [63-8*k -: 8]),
         .y (sub_col[63-8*k -: 8])
      );
   end

   if (REG_SBOX != 0) begin : g_reg_sbox
      logic        pend_vld_r;
      logic [2:0]  pend_idx;
      logic [63:0] pend_col;

      always_ff @(posedge clk) begin
         if (reset) pend_vld_r <= 1'b0;
         else       pend_vld_r <= in_hs;
      end

      always_ff @(posedge clk) begin
         if (in_hs) begin
            pend_idx <= wcnt;
            pend_col <= sub_col;
         end
      end

      assign wr_en    = pend_vld_r;
      assign wr_idx   = pend_idx;
      assign wr_data  = pend_col;
      assign pend_vld = pend_vld_r;
   end else begin : g_direct
      assign wr_en    = in_hs;
      assign wr_idx   = wcnt;
      assign wr_data  = sub_col;
      assign pend_vld = 1'b0;
   end

   // NOTE: the column store has no reset; the counters and FSM decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (wr_en) col_buf[wr_idx] <= wr_data;
   end

   // Bypass the column being written this cycle so the first output register load sees it.
   always_comb begin
      for (int k = 0; k < 8; k++)
         buf_view[k] = (wr_en && wr_idx == 3'(k)) ? wr_data : col_buf[k];
   end

   always_comb begin
      logic [2:0] src;
      shifted = '0;
      src     = 3'd0;
      for (int i = 0; i < 8; i++) begin
         src = rcnt_nxt + (perm_q ? SIGMA_Q[3*i +: 3] : 3'(i));
         shifted[63-8*i -: 8] = buf_view[src][63-8*i -: 8];
      end
   end

   // NOTE: every combinational output gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      case (state)
         ST_LOAD:
            if (in_hs && wcnt == 3'd7)
               state_nxt = (REG_SBOX != 0) ? ST_FLUSH : ST_DRAIN;
         ST_FLUSH:
            state_nxt = ST_DRAIN;
         ST_DRAIN:
            if (out_hs) begin
               rcnt_nxt = (rcnt == 3'd7) ? 3'd0 : rcnt + 3'd1;
               if (rcnt == 3'd7) state_nxt = ST_LOAD;
            end
         default:
            state_nxt = ST_LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_LOAD;
         wcnt    <= 3'd0;
         rcnt    <= 3'd0;
         perm_q  <= 1'b0;
         out_col <= '0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
         if (in_hs) begin
            wcnt <= (wcnt == 3'd7) ? 3'd0 : wcnt + 3'd1;
            if (wcnt == 3'd0) perm_q <= in_perm_q;
         end
         // Reloading with an unchanged index and buffer keeps out_col stable during stalls.
         if (state_nxt == ST_DRAIN) out_col <= shifted;
      end
   end
endmodule
